// File: rtl/avalon_msg_length_limiter_if.sv
// Avalon-ST bundle shared by the protocol enforcer chain: data/empty/sop/eop
// with a valid/ready handshake.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_WIDTH-1:0]           empty;
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;

  modport master (output data, empty, valid, sop, eop, input ready);
  modport slave  (input data, empty, valid, sop, eop, output ready);
endinterface

// File: rtl/avalon_msg_length_limiter.sv
// Caps messages at MAX_MSG_BEATS beats: longer ones get an early eop and the
// rest of the message is dropped. Reports each forwarded length and truncation.
module avalon_msg_length_limiter #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_BEATS       = 64,
  parameter int LEN_WIDTH           = $clog2(MAX_MSG_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.slave           msg_in,
  avalon_st_if.master          msg_out,
  output logic                 too_long_error,
  output logic                 msg_len_valid,
  output logic [LEN_WIDTH-1:0] msg_len
);
  localparam int DATA_WIDTH  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_WIDTH = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_MSG_BEATS);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_MSG  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [LEN_WIDTH-1:0] count_reg, count_next;
  logic [LEN_WIDTH-1:0] count_inc;

  // Output stage: the beat plus the length/truncation tags that travel with it.
  logic                   out_valid_reg;
  logic [DATA_WIDTH-1:0]  out_data_reg;
  logic [EMPTY_WIDTH-1:0] out_empty_reg;
  logic                   out_sop_reg;
  logic                   out_eop_reg;
  logic [LEN_WIDTH-1:0]   out_len_reg;
  logic                   out_trunc_reg;

  logic                   msg_len_valid_reg;
  logic                   too_long_error_reg;
  logic [LEN_WIDTH-1:0]   msg_len_reg;

  logic                   in_accept;
  logic                   out_xfer;
  logic                   fwd;
  logic                   fwd_sop;
  logic                   fwd_eop;
  logic [EMPTY_WIDTH-1:0] fwd_empty;
  logic                   fwd_trunc;
  logic [LEN_WIDTH-1:0]   fwd_len;

  assign msg_in.ready = ~out_valid_reg | msg_out.ready;
  assign in_accept    = msg_in.valid & msg_in.ready;
  assign out_xfer     = out_valid_reg & msg_out.ready;
  assign count_inc    = count_reg + ONE_LEN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    fwd        = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = msg_in.eop;
    fwd_empty  = msg_in.empty;
    fwd_trunc  = 1'b0;
    fwd_len    = '0;
    if (in_accept) begin
      unique case (state_reg)
        IDLE: begin
          // A beat without sop outside a message cannot be framed; drop it.
          if (msg_in.sop) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            fwd_len = ONE_LEN;
            if (!msg_in.eop) begin
              count_next = ONE_LEN;
              state_next = IN_MSG;
            end
          end
        end
        IN_MSG: begin
          fwd     = 1'b1;
          fwd_len = count_inc;
          if (msg_in.eop) begin
            count_next = '0;
            state_next = IDLE;
          end else if (count_inc == MAX_LEN) begin
            fwd_eop    = 1'b1;
            fwd_empty  = '0;
            fwd_trunc  = 1'b1;
            count_next = '0;
            state_next = DISCARD;
          end else begin
            fwd_empty  = '0;
            count_next = count_inc;
          end
        end
        DISCARD: begin
          if (msg_in.eop) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_reg      <= 1'b0;
      out_data_reg       <= '0;
      out_empty_reg      <= '0;
      out_sop_reg        <= 1'b0;
      out_eop_reg        <= 1'b0;
      out_len_reg        <= '0;
      out_trunc_reg      <= 1'b0;
      msg_len_valid_reg  <= 1'b0;
      too_long_error_reg <= 1'b0;
      msg_len_reg        <= '0;
    end else begin
      if (fwd) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= msg_in.data;
        out_empty_reg <= fwd_empty;
        out_sop_reg   <= fwd_sop;
        out_eop_reg   <= fwd_eop;
        out_len_reg   <= fwd_len;
        out_trunc_reg <= fwd_trunc;
      end else if (out_xfer) begin
        out_valid_reg <= 1'b0;
      end
      // Status reflects what downstream actually took, one cycle later.
      msg_len_valid_reg  <= out_xfer & out_eop_reg;
      too_long_error_reg <= out_xfer & out_eop_reg & out_trunc_reg;
      if (out_xfer && out_eop_reg) begin
        msg_len_reg <= out_len_reg;
      end
    end
  end

  assign msg_out.valid  = out_valid_reg;
  assign msg_out.data   = out_data_reg;
  assign msg_out.empty  = out_empty_reg;
  assign msg_out.sop    = out_sop_reg;
  assign msg_out.eop    = out_eop_reg;
  assign msg_len_valid  = msg_len_valid_reg;
  assign too_long_error = too_long_error_reg;
  assign msg_len        = msg_len_reg;
endmodule
